// File: rtl/gpio_in_capture14.sv
// gpio_in_capture14: pad-input capture for the GPIO14 block.
// Two-flop synchronizer, optional per-pin debounce filter (GPIO_DEBOUNCE_EN),
// qualified rise/fall detection into a W1C interrupt status and a level irq.
module gpio_in_capture14 #(
  parameter int GPIO_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  pclk14,
  input  logic                  n_p_reset14,
  input  logic [GPIO_WIDTH-1:0] gpio_pin_in14,
  input  logic [GPIO_WIDTH-1:0] n_gpio_pin_oe14,
  input  logic [GPIO_WIDTH-1:0] int_rise_en,
  input  logic [GPIO_WIDTH-1:0] int_fall_en,
  input  logic [GPIO_WIDTH-1:0] int_mask,
  input  logic [GPIO_WIDTH-1:0] status_clr,
  output logic [GPIO_WIDTH-1:0] pin_data,
  output logic [GPIO_WIDTH-1:0] int_status,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] sync1;
  logic [GPIO_WIDTH-1:0] sync2;
  logic [GPIO_WIDTH-1:0] filt;
  logic [GPIO_WIDTH-1:0] next_filt;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;
  logic [GPIO_WIDTH-1:0] edge_evt;

  // Two-stage synchronizer, nothing between the stages
  always_ff @(posedge pclk14) begin
    if (!n_p_reset14) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_pin_in14;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt      [GPIO_WIDTH];
  logic [CNT_W-1:0] cnt_next [GPIO_WIDTH];

  // Per-pin stability counter: accept sync2 after DEBOUNCE_CYCLES differing samples
  always_comb begin
    next_filt = filt;
    for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != filt[i]) begin
        if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          next_filt[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounce counter registers; reset discards any pending count
  always_ff @(posedge pclk14) begin
    for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
      if (!n_p_reset14) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt_next[i];
      end
    end
  end
`else
  assign next_filt = sync2;
`endif

  // Edges are taken from the filter transition itself, so status lands with pin_data
  assign rise     = ~filt & next_filt & int_rise_en;
  assign fall     = filt & ~next_filt & int_fall_en;
  assign edge_evt = (rise | fall) & n_gpio_pin_oe14;

  // Filter output and sticky W1C status (a new event beats a same-cycle clear)
  always_ff @(posedge pclk14) begin
    if (!n_p_reset14) begin
      filt       <= '0;
      int_status <= '0;
    end else begin
      filt       <= next_filt;
      int_status <= (int_status & ~status_clr) | edge_evt;
    end
  end

  assign pin_data = filt;
  assign irq      = |(int_status & int_mask);

endmodule
